// File: rtl/ser_addsub_pkg.sv
// ser_addsub_pkg: shared definitions for the bit-serial adder/subtractor.
//   state_e      - FSM encoding (IDLE -> RUN -> DONE -> IDLE), 2 bits wide
//   WIDTH_MIN/MAX - legal operand width range
//   width_ok()   - elaboration-time range check helper
package ser_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 64;

  function automatic bit width_ok(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/ser_addsub_fadd.sv
// fadd: one-bit full-adder cell.
//   a, b, cin - addend bits and carry in
//   s         - sum bit
//   cout      - carry out (majority of the three inputs)
module fadd (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/ser_addsub.sv
// ser_addsub: bit-serial adder/subtractor, LSB first, one bit per clock.
//
// Ports:
//   clk     - rising-edge clock
//   reset   - synchronous, active-high reset
//   start   - operation request, only looked at while idle
//   sub     - 0: a+b, 1: a-b (captured with start)
//   a, b    - WIDTH-bit operands (captured with start)
//   busy    - high while bits are being processed
//   sum_bit - current serial result bit, 0 when not busy
//   done    - one-cycle completion pulse
//   result  - parallel result, held until the next completion
//   cout    - final carry out (for subtraction, 1 = no borrow)
//   ovf     - signed two's-complement overflow
//
// Handshake: a request is taken when start=1 on a clock edge while busy=0
// and done=0 (state IDLE); requests at any other time are dropped, not
// queued. The operation then occupies WIDTH busy cycles followed by one
// done cycle, so the next request can be taken on the cycle after done.
module ser_addsub
  import ser_addsub_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             sum_bit,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("ser_addsub: WIDTH must be within 2..64");
  end

  logic [1:0]       state;
  logic [WIDTH-1:0] areg;
  logic [WIDTH-1:0] breg;
  logic [WIDTH-1:0] resreg;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             fa_s;
  logic             fa_co;

  fadd u_fadd (
    .a    (areg[0]),
    .b    (breg[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_co)
  );

  assign busy    = (state == ST_RUN);
  assign done    = (state == ST_DONE);
  assign sum_bit = busy ? fa_s : 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      areg   <= '0;
      breg   <= '0;
      resreg <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            areg  <= a;
            // Subtraction as A + ~B + 1: invert B here, seed the carry with 1.
            breg  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= CNT_W'(WIDTH - 1);
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          carry  <= fa_co;
          areg   <= {1'b0, areg[WIDTH-1:1]};
          breg   <= {1'b0, breg[WIDTH-1:1]};
          resreg <= {fa_s, resreg[WIDTH-1:1]};
          cnt    <= cnt - CNT_W'(1);
          if (cnt == '0) begin
            // Last bit is the MSB: carry holds the carry into it, fa_co the
            // carry out of it; their difference is signed overflow.
            result <= {fa_s, resreg[WIDTH-1:1]};
            cout   <= fa_co;
            ovf    <= carry ^ fa_co;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ser_addsub.sv
// tb_ser_addsub: directed + random checks of ser_addsub at WIDTH=16 and
// WIDTH=4, with a scoreboard queue of expected {cout, ovf, result}.
module tb_ser_addsub;

  // ---------------- clock / reset / DUTs ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        start, sub;
  logic [15:0] a, b;
  logic        busy, sum_bit, done, cout, ovf;
  logic [15:0] result;

  logic        start4, sub4;
  logic [3:0]  a4, b4;
  logic        busy4, sum_bit4, done4, cout4, ovf4;
  logic [3:0]  result4;

  always #5 clk = ~clk;

  ser_addsub #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .sum_bit(sum_bit), .done(done), .result(result),
    .cout(cout), .ovf(ovf)
  );

  ser_addsub #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .busy(busy4), .sum_bit(sum_bit4), .done(done4), .result(result4),
    .cout(cout4), .ovf(ovf4)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int fails  = 0;
  logic [17:0] exp_q[$];
  logic [5:0]  exp_q4[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {cout, ovf, result} for a 16-bit add or subtract.
  function automatic logic [17:0] model16(input logic s, input logic [15:0] x, input logic [15:0] y);
    logic [15:0] yy;
    logic [16:0] t;
    logic        v;
    yy = s ? ~y : y;
    t  = {1'b0, x} + {1'b0, yy} + 17'(s);
    v  = (x[15] == yy[15]) && (t[15] != x[15]);
    return {t[16], v, t[15:0]};
  endfunction

  // ---------------- driver ----------------
  // Called shortly after a rising edge while the DUT is idle; returns shortly
  // after the rising edge that ends the done cycle (first idle cycle).
  // Between cycles ig_lo..ig_hi a stray start with a=0xFFFF is driven.
  task automatic do_op16(input logic s, input logic [15:0] x, input logic [15:0] y,
                         input logic [17:0] e, input int ig_lo, input int ig_hi);
    logic [15:0] ser;
    logic [17:0] got;
    logic [17:0] want;
    int          ndone;
    exp_q.push_back(e);
    start = 1'b1; sub = s; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    sub   = 1'($urandom_range(0, 1));
    a     = 16'($urandom);
    b     = 16'($urandom);
    ser   = '0;
    ndone = 0;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      chk("busy", busy, (c <= 16));
      chk("done", done, (c == 17));
      if (c <= 16) ser[c-1] = sum_bit;
      else chk("sum_bit_idle", sum_bit, 0);
      if (done) begin
        ndone++;
        chk("sb_depth", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          want = exp_q.pop_front();
          got  = {cout, ovf, result};
          chk("result", got, want);
          chk("serial_bits", ser, want[15:0]);
        end
      end
      start = (c >= ig_lo) && (c <= ig_hi) && (c < 17);
      if (start) a = 16'hFFFF;
    end
    chk("done_count", ndone, 1);
    if (ndone == 0 && exp_q.size() > 0) void'(exp_q.pop_front());
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] rx, ry;
    logic        rs;
    logic [5:0]  w4;
    int          nd4;

    reset = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_sum_bit", sum_bit, 0);
    chk("rst4_state", {busy4, done4, result4, cout4, ovf4, sum_bit4}, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed arithmetic cases
    do_op16(1'b0, 16'h1234, 16'h0FED, {1'b0, 1'b0, 16'h2221}, 0, -1);

    // Idle hold: result stays, no spurious done
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_result", result, 16'h2221);
      chk("hold_done", done, 0);
      chk("hold_busy", busy, 0);
      @(posedge clk); #1;
    end

    do_op16(1'b0, 16'h7FFF, 16'h0001, {1'b0, 1'b1, 16'h8000}, 0, -1);
    do_op16(1'b0, 16'hFFFF, 16'h0001, {1'b1, 1'b0, 16'h0000}, 0, -1);
    do_op16(1'b1, 16'h0005, 16'h0007, {1'b0, 1'b0, 16'hFFFE}, 0, -1);
    do_op16(1'b1, 16'h8000, 16'h0001, {1'b1, 1'b1, 16'h7FFF}, 0, -1);

    // Stray start during busy cycles 3..8 is ignored
    do_op16(1'b0, 16'h0001, 16'h0001, {1'b0, 1'b0, 16'h0002}, 3, 8);

    // Back-to-back: start in cycle 18 of the previous op, then random ops
    for (int i = 0; i < 6; i++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      rs = 1'($urandom_range(0, 1));
      do_op16(rs, rx, ry, model16(rs, rx, ry), 0, -1);
    end

    // Reset in cycle 9 of an operation
    start = 1'b1; sub = 1'b0; a = 16'h1234; b = 16'h0FED;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      chk("busy_pre_reset", busy, 1);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_result", result, 0);
    chk("abort_done", done, 0);
    chk("abort_flags", {cout, ovf, sum_bit}, 0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
    end
    @(posedge clk); #1;
    do_op16(1'b0, 16'h0003, 16'h0004, {1'b0, 1'b0, 16'h0007}, 0, -1);

    // WIDTH=4 instance: 0x9 + 0x8
    exp_q4.push_back({1'b1, 1'b1, 4'h1});
    start4 = 1'b1; sub4 = 1'b0; a4 = 4'h9; b4 = 4'h8;
    @(posedge clk); #1;
    start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
    nd4 = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk("w4_busy", busy4, (c <= 4));
      chk("w4_done", done4, (c == 5));
      if (done4) begin
        nd4++;
        chk("w4_sb_depth", exp_q4.size(), 1);
        if (exp_q4.size() > 0) begin
          w4 = exp_q4.pop_front();
          chk("w4_result", {cout4, ovf4, result4}, w4);
        end
      end
    end
    chk("w4_done_count", nd4, 1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/ser_addsub.md
Name: ser_addsub

Overview:
- Parametrised bit-serial adder/subtractor, LSB first, one bit per clock.
- Loads two WIDTH-bit operands on a start pulse and streams the sum/difference bits out serially.
- Collects the result into a parallel register and flags completion with carry and signed overflow.
- Successor of the fixed 16-bit serial adder: adds width generality, subtraction, a start/busy/done handshake and an automatic bit counter, so external mode sequencing is no longer needed.

Parameters:
- WIDTH, 16, operand/result width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, never overridden.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- sub  in  1  0 = a+b, 1 = a-b; sampled with start
- a  in  WIDTH  operand A; sampled with start
- b  in  WIDTH  operand B; sampled with start
- busy  out  1  high while bits are being processed
- sum_bit  out  1  current serial result bit (combinational), valid while busy
- done  out  1  one-cycle pulse; result, cout and ovf valid
- result  out  WIDTH  parallel result; holds until the next completion
- cout  out  1  final carry out; for sub, 1 = no borrow
- ovf  out  1  signed two's-complement overflow

Behaviour:
- Reset, sampled on the clk edge while reset=1:
  - state=IDLE
  - busy, done, result, cout, ovf, internal shift registers, carry flop and counter all 0
  - sum_bit=0
- State machine: IDLE -> RUN -> DONE -> IDLE.
- IDLE, start=1 at edge E0:
  - areg<=a
  - breg<=(sub ? ~b : b)
  - carry<=sub, so subtraction is A + ~B + 1
  - cnt<=WIDTH-1
  - go to RUN
- IDLE, start=0: hold. All outputs except done keep their values.
- RUN, each cycle (busy=1):
  - sum_bit = areg[0]^breg[0]^carry
  - carry <= majority(areg[0],breg[0],carry)
  - areg and breg shift right by 1, zero fill
  - resreg shifts right with sum_bit entering the MSB
  - cnt decrements
- RUN, at cnt==0 (last bit):
  - result <= {sum_bit, resreg[WIDTH-1:1]}
  - cout <= carry out of the MSB
  - ovf <= carry into the MSB XOR carry out of the MSB
  - go to DONE
- DONE: done=1 for exactly one cycle, busy=0, then IDLE unconditionally.
- Latency:
  - start sampled at E0 -> busy high in cycles 1..WIDTH
  - done high in cycle WIDTH+1
  - a new start is accepted in cycle WIDTH+2 at the earliest
  - throughput is one operation per WIDTH+2 cycles
- start in RUN or DONE is ignored, not queued. Operand changes after E0 have no effect.
- sum_bit=0 outside RUN.
- Reset mid-operation: aborts immediately, no done pulse, and all outputs clear per the reset rule.
- The carry flop is not shared between operations; each start reinitialises it from sub.

Decomposition:
- Package ser_addsub_pkg:
  - state enum {IDLE, RUN, DONE} as a 2-bit type
  - WIDTH bounds-check constants
- The one-bit full-adder cell fadd is reused as the single sub-module.
- The bit slice, counter and FSM stay inline in ser_addsub.

Test Plan (WIDTH=16):
- add 0x1234 + 0x0FED -> done in cycle 17, result=0x2221, cout=0, ovf=0; serial bits LSB-first match 0x2221.
- add 0x7FFF + 0x0001 -> result=0x8000, cout=0, ovf=1; add 0xFFFF + 0x0001 -> result=0x0000, cout=1, ovf=0.
- sub 0x0005 - 0x0007 -> result=0xFFFE, cout=0 (borrow), ovf=0; sub 0x8000 - 0x0001 -> result=0x7FFF, cout=1, ovf=1.
- start re-asserted with a=0xFFFF during busy cycles 3..8 of 0x0001+0x0001 -> ignored; result=0x0002; single done pulse; the next start is accepted in cycle 18.
- reset asserted in cycle 9 of 0x1234+0x0FED -> next cycle busy=0, result=0, no done; the following 0x0003+0x0004 gives 0x0007.
- WIDTH=4 instance: add 0x9 + 0x8 -> result=0x1, cout=1, ovf=1; done in cycle 5.
